// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and arbiter FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACT  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward
// from (last+1) with wrap-around. No state; the caller owns the pointer.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   last,
  output logic [REQ_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Walk the candidates in priority order; the first hit wins.
  always_comb begin
    logic [REQ_W-1:0] cand;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = last;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap keeps the search correct for non-power-of-two NUM_REQ.
      cand = (cand == REQ_W'(NUM_REQ - 1)) ? '0 : cand + REQ_W'(1);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters with round-robin fairness,
// one byte per grant, and sequences the transmitter's start/active/done handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned ACT_TIMEOUT = 1024,
  localparam int unsigned REQ_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_parity,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             done,
  output logic [REQ_W-1:0]               owner,
  output logic                           busy,
  output logic                           timeout_err,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_parity_en,
  input  logic                           tx_active,
  input  logic                           tx_done
);

  localparam int unsigned CNT_W = ($clog2(ACT_TIMEOUT) < 1) ? 1 : $clog2(ACT_TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [REQ_W-1:0]       owner_q, owner_d;
  logic [REQ_W-1:0]       last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_parity_en_q, tx_parity_en_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [REQ_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req),
    .last        (last_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Split the flat request data bus into per-requester bytes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Next-state and registered-output logic for the launch/handshake FSM.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    busy_d         = busy_q;
    timeout_err_d  = timeout_err_q;
    tx_data_d      = tx_data_q;
    tx_parity_en_d = tx_parity_en_q;
    cnt_d          = cnt_q;
    tx_start_d     = 1'b0;
    ack_d          = '0;
    done_d         = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d        = grant_idx;
          tx_data_d      = req_bytes[grant_idx];
          tx_parity_en_d = req_parity[grant_idx];
          busy_d         = 1'b1;
          state_d        = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_d     = 1'b1;
        ack_d[owner_q] = 1'b1;
        last_d         = owner_q;
        cnt_d          = '0;
        state_d        = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (tx_active) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(ACT_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        // tx_active was seen first, so a tx_done level left over from the
        // previous byte cannot terminate this wait early.
        if (!tx_active && tx_done) begin
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      last_q         <= REQ_W'(NUM_REQ - 1);
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      tx_parity_en_q <= 1'b0;
      ack_q          <= '0;
      done_q         <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      tx_parity_en_q <= tx_parity_en_d;
      ack_q          <= ack_d;
      done_q         <= done_d;
      cnt_q          <= cnt_d;
    end
  end

  assign ack          = ack_q;
  assign done         = done_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign tx_parity_en = tx_parity_en_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NUM_REQ independent byte requesters.
- Fair round-robin arbitration; one byte per grant.
- Sequences the transmitter's start/active/done protocol and returns per-requester accept and completion pulses.
- Sits between client logic (command engines, debug printers) and the uart_tx instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- REQ_W, 2: owner index width, equals clog2(NUM_REQ); derived, not overridden.
- ACT_TIMEOUT, 1024: cycles to wait for tx_active after tx_start before aborting.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester level request; held high with stable data until ack.
- req_data  input  NUM_REQ*8  byte for requester i at bits [8i+7:8i].
- req_parity  input  NUM_REQ  per-requester parity enable.
- ack  output  NUM_REQ  one-cycle pulse: requester's byte latched and launched.
- done  output  NUM_REQ  one-cycle pulse: requester's byte fully transmitted (stop bit complete).
- owner  output  REQ_W  index of current/last owner.
- busy  output  1  high from arbitration until completion or abort.
- timeout_err  output  1  sticky; set on ACT_TIMEOUT expiry, cleared only by rst.
- tx_start  output  1  to uart_tx; one-cycle pulse.
- tx_data  output  8  to uart_tx; registered, stable from tx_start until done.
- tx_parity_en  output  1  to uart_tx; registered with tx_data.
- tx_active  input  1  from uart_tx.
- tx_done  input  1  from uart_tx; level, stays high until next start.

Behaviour:
- Reset values: ack=0, done=0, owner=0, busy=0, timeout_err=0, tx_start=0, tx_data=0, tx_parity_en=0, rr pointer last=NUM_REQ-1, state=IDLE.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_ACT, WAIT_DONE.
- IDLE, req != 0 at edge n:
  - Winner = first set bit searching (last+1) mod NUM_REQ upward, with wrap.
  - Latch owner, tx_data, tx_parity_en; set busy; go LAUNCH.
  - req == 0: stay IDLE.
- LAUNCH, one cycle:
  - tx_start=1 and ack[owner]=1, both at edge n+1.
  - last <= owner.
  - Go WAIT_ACT and clear the timeout counter.
- WAIT_ACT:
  - tx_active=1: go WAIT_DONE.
  - Otherwise the counter increments.
  - Counter reaches ACT_TIMEOUT-1: set timeout_err, clear busy, go IDLE. No done pulse.
- WAIT_DONE:
  - Exit on tx_active=0 && tx_done=1: done[owner]=1 for one cycle, busy=0, go IDLE.
  - A stale tx_done level from the previous byte cannot end this wait, because WAIT_ACT already required tx_active.
- Back-to-back:
  - The next arbitration may occur the cycle after done.
  - Minimum gap between tx_start pulses is frame time + 3 cycles.
- Requests:
  - A requester dropping req before ack is ignored if not yet latched.
  - Once in LAUNCH, the byte is committed.
- Simultaneous requests: exactly one ack per launch, round-robin order.
- A requester re-asserting immediately after its ack waits behind every other pending requester.
- Single requester: granted repeatedly with no starvation penalty.
- ack and done never assert in the same cycle for the same launch.
- At most one bit of ack and one bit of done is set in any cycle.
- tx_data and tx_parity_en change only in IDLE→LAUNCH.
- Reset mid-transmission: all state returns to reset values immediately; no done pulse is issued. The transmitter is reset by the same rst.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants IDLE=2'd0, LAUNCH=2'd1, WAIT_ACT=2'd2, WAIT_DONE=2'd3.
  - Byte width constant UART_DATA_W=8.
- One natural sub-module, rr_arbiter:
  - Combinational round-robin priority pick from (req, last) to grant_idx and grant_valid.
  - Parameterised by NUM_REQ; reusable by a future RX dispatcher.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5, parity=1, uart_tx at clk/baud=16 → tx_start and ack[0] at edge n+1; serial frame 0,10100101 LSB-first, parity bit, 1; done[0] after stop bit; busy low the next cycle.
- Contention: req=4'b1111 held, bytes 8'h10/11/12/13 → launch order 0,1,2,3,0 and tx_data sequence 10,11,12,13,10; exactly one ack per frame.
- Pointer fairness: last=1, req=4'b1001 → requester 3 granted before 0; then req=4'b0001 only → 0 granted.
- Stale done: two back-to-back frames from requester 2 → second done[2] occurs only after the second frame's stop bit, not immediately after launch.
- Timeout: stub tx_active tied 0, ACT_TIMEOUT=8 → timeout_err set 8 cycles after WAIT_ACT entry, busy=0, no done pulse, next req re-arbitrated.
- Reset mid-frame: assert rst during data bit 4 → all outputs at reset values in the same cycle; after release, req=4'b0100 completes normally with owner=2.
